// File: rtl/iddmm_pkg.sv
// Shared types, width helpers and the reference product for the limb-serial multiplier.
package iddmm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_LIMB_W = 128;
    localparam int MAX_LIMBS  = 16;
    localparam int MAX_N      = MAX_LIMB_W * MAX_LIMBS;

    function automatic int n_bits(input int limb_w, input int k);
        return limb_w * k;
    endfunction

    function automatic int prod_bits(input int limb_w, input int k);
        return 2 * limb_w * k;
    endfunction

    // Counters need at least one bit even when there is a single limb.
    function automatic int cnt_bits(input int k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

    function automatic logic [2*MAX_N-1:0] golden_mul(input logic [MAX_N-1:0] a,
                                                      input logic [MAX_N-1:0] b);
        logic [2*MAX_N-1:0] wa;
        logic [2*MAX_N-1:0] wb;
        wa = {{MAX_N{1'b0}}, a};
        wb = {{MAX_N{1'b0}}, b};
        return wa * wb;
    endfunction

endpackage

// File: rtl/iddmm_mac_limb.sv
// Single-limb multiply-accumulate: p = a*b + c + d, which can never overflow 2*LIMB_W bits.
module iddmm_mac_limb #(
    parameter int LIMB_W = 64
) (
    input  logic [LIMB_W-1:0]   i_a,
    input  logic [LIMB_W-1:0]   i_b,
    input  logic [LIMB_W-1:0]   i_c,
    input  logic [LIMB_W-1:0]   i_d,
    output logic [2*LIMB_W-1:0] o_p
);

    logic [2*LIMB_W-1:0] w_prod;

    assign w_prod = (2*LIMB_W)'(i_a) * (2*LIMB_W)'(i_b);
    assign o_p    = w_prod + (2*LIMB_W)'(i_c) + (2*LIMB_W)'(i_d);

endmodule

// File: rtl/iddmm_mul_iter.sv
// Limb-serial N x N -> 2N unsigned multiplier: one LIMB_W x LIMB_W MAC step per cycle,
// K*K steps per product, valid/ready on both sides.
module iddmm_mul_iter
    import iddmm_pkg::*;
#(
    parameter int LIMB_W    = 64,
    parameter int NUM_LIMBS = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LIMB_W*NUM_LIMBS-1:0]     x,
    input  logic [LIMB_W*NUM_LIMBS-1:0]     y,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [2*LIMB_W*NUM_LIMBS-1:0]   result,
    output logic                            busy
);

    localparam int N  = n_bits(LIMB_W, NUM_LIMBS);
    localparam int N2 = prod_bits(LIMB_W, NUM_LIMBS);
    localparam int CW = cnt_bits(NUM_LIMBS);
    localparam int IW = CW + 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_LIMBS - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [LIMB_W-1:0]   r_x     [NUM_LIMBS];
    logic [LIMB_W-1:0]   r_y     [NUM_LIMBS];
    logic [LIMB_W-1:0]   r_acc   [2*NUM_LIMBS];
    logic [LIMB_W-1:0]   w_acc_next [2*NUM_LIMBS];
    logic [LIMB_W-1:0]   r_carry;
    logic [LIMB_W-1:0]   w_c;
    logic [CW-1:0]       r_i;
    logic [CW-1:0]       r_j;
    logic [IW-1:0]       w_lo_idx;
    logic [IW-1:0]       w_hi_idx;
    logic [2*LIMB_W-1:0] w_p;
    logic                w_last_i;
    logic                w_last;
    logic                w_in_hs;
    logic                r_out_valid;
    logic [N2-1:0]       r_result;
    logic [N2-1:0]       w_acc_flat;

    assign w_in_hs  = in_valid && in_ready;
    assign w_last_i = (r_i == LAST);
    assign w_last   = w_last_i && (r_j == LAST);
    assign w_lo_idx = IW'(r_i) + IW'(r_j);
    assign w_hi_idx = IW'(r_j) + IW'(NUM_LIMBS);
    // The carry belongs to the previous column step; a new row starts with none.
    assign w_c      = (r_i == '0) ? '0 : r_carry;

    iddmm_mac_limb #(.LIMB_W(LIMB_W)) u_mac (
        .i_a (r_x[r_i]),
        .i_b (r_y[r_j]),
        .i_c (r_acc[w_lo_idx]),
        .i_d (w_c),
        .o_p (w_p)
    );

    always_comb begin
        for (int k = 0; k < 2*NUM_LIMBS; k++) begin
            w_acc_next[k] = r_acc[k];
        end
        w_acc_next[w_lo_idx] = w_p[LIMB_W-1:0];
        if (w_last_i) begin
            w_acc_next[w_hi_idx] = w_p[2*LIMB_W-1:LIMB_W];
        end
        w_acc_flat = '0;
        for (int k = 0; k < 2*NUM_LIMBS; k++) begin
            w_acc_flat[k*LIMB_W +: LIMB_W] = w_acc_next[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_in_hs)   w_state_next = MUL;
            MUL:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == IDLE) && !rst;
        busy     = (r_state == MUL) || (r_state == DONE);
    end

    // Operands are captured only on the input handshake.
    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            for (int k = 0; k < NUM_LIMBS; k++) begin
                r_x[k] <= x[k*LIMB_W +: LIMB_W];
                r_y[k] <= y[k*LIMB_W +: LIMB_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i         <= '0;
            r_j         <= '0;
            r_carry     <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            for (int k = 0; k < 2*NUM_LIMBS; k++) begin
                r_acc[k] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_in_hs) begin
                        r_i     <= '0;
                        r_j     <= '0;
                        r_carry <= '0;
                        for (int k = 0; k < 2*NUM_LIMBS; k++) begin
                            r_acc[k] <= '0;
                        end
                    end
                end
                MUL: begin
                    for (int k = 0; k < 2*NUM_LIMBS; k++) begin
                        r_acc[k] <= w_acc_next[k];
                    end
                    r_carry <= w_p[2*LIMB_W-1:LIMB_W];
                    if (w_last_i) begin
                        r_i <= '0;
                        r_j <= r_j + CW'(1);
                    end else begin
                        r_i <= r_i + CW'(1);
                    end
                    if (w_last) begin
                        r_j         <= '0;
                        r_result    <= w_acc_flat;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule
